// File: rtl/rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rx_fifo
// Brief    : UART receive buffer; parity-checks each captured frame and queues
//            it in a first-word-fall-through FIFO with a valid/ready read port
//            and a sticky overflow flag. Optional RX_FIFO_PARITY_CHECK_EN adds
//            per-entry parity-error storage.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_parity,
  input  logic                    wr_parity_present,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_parity_err,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef RX_FIFO_PARITY_CHECK_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;

  logic          w_rd_fire;
  logic          w_wr_accept;
  logic          w_drop;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_head;

`ifdef RX_FIFO_PARITY_CHECK_EN
  logic w_parity_err;
  assign w_parity_err = wr_parity_present & (^wr_data ^ wr_parity ^ 1'(PARITY_ODD));
  assign w_wr_entry   = {w_parity_err, wr_data};
`else
  logic w_unused_parity;
  assign w_unused_parity = wr_parity ^ wr_parity_present ^ 1'(PARITY_ODD);
  assign w_wr_entry      = wr_data;
`endif

  assign w_rd_fire   = ~empty_q & rd_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign w_wr_accept = wr_valid & (~full_q | w_rd_fire);
  assign w_drop      = wr_valid & full_q & ~w_rd_fire;

  always_comb begin
    count_d = count_q;
    case ({w_wr_accept, w_rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = w_drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (w_wr_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_rd_fire)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; stale contents are masked by empty_q.
  always_ff @(posedge clk) begin
    if (w_wr_accept) mem_q[wr_ptr_q] <= w_wr_entry;
  end

  assign w_head   = mem_q[rd_ptr_q];
  assign rd_valid = ~empty_q;
  assign rd_data  = empty_q ? '0 : w_head[DATA_WIDTH-1:0];
`ifdef RX_FIFO_PARITY_CHECK_EN
  assign rd_parity_err = ~empty_q & w_head[DATA_WIDTH];
`else
  assign rd_parity_err = 1'b0;
`endif

  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_rx_fifo
// Brief    : Self-checking bench for rx_fifo; directed steps plus random
//            traffic compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_rx_fifo;

  localparam int DW         = 8;
  localparam int DEPTH      = 8;
  localparam int PARITY_ODD = 0;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_parity;
  logic          wr_parity_present;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_parity_err;
  logic [3:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          ovf_clr;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of {parity_err, data} plus sticky overflow flag.
  logic [DW:0] model_q[$];
  logic        model_ovf;

  rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PARITY_ODD(PARITY_ODD)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_valid          (wr_valid),
    .wr_data           (wr_data),
    .wr_parity         (wr_parity),
    .wr_parity_present (wr_parity_present),
    .rd_ready          (rd_ready),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .rd_parity_err     (rd_parity_err),
    .count             (count),
    .full              (full),
    .empty             (empty),
    .overflow          (overflow),
    .ovf_clr           (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [DW-1:0] d, input logic p, input logic pp);
`ifdef RX_FIFO_PARITY_CHECK_EN
    int ones = $countones(d) + int'(p) + PARITY_ODD;
    return pp && (ones % 2 == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    int n = model_q.size();
    chk({tag, ":count"},    32'(count),         32'(n));
    chk({tag, ":full"},     32'(full),          32'(n == DEPTH));
    chk({tag, ":empty"},    32'(empty),         32'(n == 0));
    chk({tag, ":rd_valid"}, 32'(rd_valid),      32'(n != 0));
    chk({tag, ":rd_data"},  32'(rd_data),       (n != 0) ? 32'(model_q[0][DW-1:0]) : 32'd0);
    chk({tag, ":perr"},     32'(rd_parity_err), (n != 0) ? 32'(model_q[0][DW]) : 32'd0);
    chk({tag, ":overflow"}, 32'(overflow),      32'(model_ovf));
  endtask

  // Called just after a falling edge; drives one clock of stimulus.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic wp,
                       input logic wpp, input logic rr, input logic oc, input string tag);
    bit fire, accept, drop;
    logic [DW:0] entry;
    wr_valid = wv; wr_data = wd; wr_parity = wp; wr_parity_present = wpp;
    rd_ready = rr; ovf_clr = oc;
    #1 check_all({tag, "/pre"});
    fire   = rr && (model_q.size() > 0);
    accept = wv && ((model_q.size() < DEPTH) || fire);
    drop   = wv && (model_q.size() == DEPTH) && !fire;
    entry  = {exp_perr(wd, wp, wpp), wd};
    @(posedge clk);
    if (fire)   void'(model_q.pop_front());
    if (accept) model_q.push_back(entry);
    if (drop)        model_ovf = 1'b1;
    else if (oc)     model_ovf = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    #1 check_all({tag, "/post"});
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_parity = 1'b0;
    wr_parity_present = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    model_ovf = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("reset");

    // Single frames with parity
    cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, "wr5A");
    chk("5A_perr", 32'(rd_parity_err), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "rd5A");
    cycle(1'b1, 8'h5B, 1'b0, 1'b1, 1'b0, 1'b0, "wr5B");
`ifdef RX_FIFO_PARITY_CHECK_EN
    chk("5B_perr", 32'(rd_parity_err), 32'd1);
`else
    chk("5B_perr", 32'(rd_parity_err), 32'd0);
`endif
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "rd5B");

    // Fill, overflow, drain, clear
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, "fill");
    chk("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, "drop09");
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 32'(rd_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "drain");
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "empty_rd");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "ovf_clr");
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous read and write
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0, "fill2");
    cycle(1'b1, 8'h18, 1'b0, 1'b0, 1'b1, 1'b0, "rw_full");
    chk("rw_full_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      chk("rw_order", 32'(rd_data), 32'(8'h10 + i));
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "drain2");
    end

    // Wrap-around with interleaved write/read pairs
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, "wrap_wr");
      chk("wrap_data", 32'(rd_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "wrap_rd");
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b0, "pre_rst");
    #2 rst_n = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #1 check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "wrA5");
    chk("A5_data", 32'(rd_data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "rdA5");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
